// File: rtl/uart_pkg.sv
// Shared constants, receiver FSM state type and an elaboration-time log2 helper
// for the parametrised UART receiver.
package uart_pkg;

   localparam int unsigned PAR_NONE = 0;
   localparam int unsigned PAR_ODD  = 1;
   localparam int unsigned PAR_EVEN = 2;

   typedef enum logic [2:0] {
      StWaitIdle,
      StIdle,
      StStart,
      StData,
      StParity,
      StStop
   } rx_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) res = i + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output; the head word
// reads as zero while the FIFO is empty.
module uart_rx_sfifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 9,
   parameter int unsigned DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_push,
   input  logic [WIDTH-1:0]      i_data,
   input  logic                  i_pop,
   output logic [WIDTH-1:0]      o_data,
   output logic                  o_valid,
   output logic                  o_full,
   output logic [clog2(DEPTH):0] o_level
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_wr;
   logic             w_rd;

   assign o_valid = (r_level != '0);
   assign o_full  = (r_level == FULL_LVL);
   assign o_level = r_level;
   assign o_data  = o_valid ? r_mem[r_rptr] : '0;

   // A full FIFO still takes a write when the head leaves in the same cycle.
   assign w_wr = i_push && (!o_full || i_pop);
   assign w_rd = i_pop && o_valid;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + 1'b1;
         if (w_rd) r_rptr <= r_rptr + 1'b1;
         if (w_wr && !w_rd) begin
            r_level <= r_level + 1'b1;
         end else if (w_rd && !w_wr) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// UART receiver with configurable bit time, width and parity, 3-sample majority voting,
// start-glitch rejection, break/framing/overrun reporting and a FWFT receive FIFO.
module uart_rx_fifo_param
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = PAR_NONE,
   parameter int unsigned FIFO_DEPTH   = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       uart_rxd,
   output logic [DATA_BITS-1:0]       rx_data,
   output logic                       rx_perr,
   output logic                       rx_valid,
   input  logic                       rx_ready,
   output logic [clog2(FIFO_DEPTH):0] rx_level,
   output logic                       err_frame,
   output logic                       err_overrun,
   output logic                       break_det
);

   localparam int unsigned CW  = clog2(CLKS_PER_BIT);
   localparam int unsigned MID = CLKS_PER_BIT / 2;
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] SMP_A    = CW'(MID - 1);
   localparam logic [CW-1:0] SMP_B    = CW'(MID);
   localparam logic [CW-1:0] SMP_C    = CW'(MID + 1);
   localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

   logic [1:0]           r_sync;
   logic [1:0]           r_sync_vld;
   logic                 r_prev;
   rx_state_t            r_state;
   logic [CW-1:0]        r_bit_cnt;
   logic                 r_smp_a;
   logic                 r_smp_b;
   logic [DATA_BITS-1:0] r_shift;
   logic [3:0]           r_nbit;
   logic                 r_perr;
   logic                 r_pbit;
   logic                 r_err_frame;
   logic                 r_break;
   logic                 r_err_ovr;

   logic                 w_rxs;
   logic                 w_fall;
   logic                 w_dec;
   logic                 w_vote;
   logic                 w_par;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic [DATA_BITS:0]   w_fifo_data;

   assign w_rxs  = r_sync[1];
   assign w_fall = r_prev && !w_rxs;
   assign w_dec  = (r_bit_cnt == SMP_C);
   assign w_vote = (r_smp_a & r_smp_b) | (r_smp_a & w_rxs) | (r_smp_b & w_rxs);
   assign w_par  = (^r_shift) ^ w_vote;
   assign w_push = (r_state == StStop) && w_dec && w_vote;
   assign w_pop  = rx_valid && rx_ready;

   assign err_frame   = r_err_frame;
   assign err_overrun = r_err_ovr;
   assign break_det   = r_break;

   // r_sync_vld keeps WAIT_IDLE from trusting the reset value of the synchroniser.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync     <= 2'b11;
         r_sync_vld <= 2'b00;
         r_prev     <= 1'b1;
         r_err_ovr  <= 1'b0;
      end else begin
         r_sync     <= {r_sync[0], uart_rxd};
         r_sync_vld <= {r_sync_vld[0], 1'b1};
         r_prev     <= w_rxs;
         r_err_ovr  <= w_push && w_full && !w_pop;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StWaitIdle;
         r_bit_cnt   <= '0;
         r_smp_a     <= 1'b1;
         r_smp_b     <= 1'b1;
         r_shift     <= '0;
         r_nbit      <= '0;
         r_perr      <= 1'b0;
         r_pbit      <= 1'b0;
         r_err_frame <= 1'b0;
         r_break     <= 1'b0;
      end else begin
         r_err_frame <= 1'b0;
         r_bit_cnt   <= (r_bit_cnt == CNT_MAX) ? '0 : r_bit_cnt + 1'b1;
         if (r_bit_cnt == SMP_A) r_smp_a <= w_rxs;
         if (r_bit_cnt == SMP_B) r_smp_b <= w_rxs;
         unique case (r_state)
            StWaitIdle: begin
               if (r_sync_vld[1] && w_rxs) begin
                  r_state <= StIdle;
                  r_break <= 1'b0;
               end
            end
            StIdle: begin
               if (w_fall) begin
                  r_state   <= StStart;
                  r_bit_cnt <= '0;
                  r_nbit    <= '0;
                  r_perr    <= 1'b0;
                  r_pbit    <= 1'b0;
               end
            end
            StStart: begin
               if (w_dec) r_state <= w_vote ? StIdle : StData;
            end
            StData: begin
               if (w_dec) begin
                  r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                  r_nbit  <= r_nbit + 1'b1;
                  if (r_nbit == LAST_BIT) r_state <= (PARITY != PAR_NONE) ? StParity : StStop;
               end
            end
            StParity: begin
               if (w_dec) begin
                  r_pbit  <= w_vote;
                  r_perr  <= (PARITY == PAR_ODD) ? !w_par : w_par;
                  r_state <= StStop;
               end
            end
            StStop: begin
               if (w_dec) begin
                  if (w_vote) begin
                     r_state <= StIdle;
                  end else if ((r_shift == '0) && !r_pbit) begin
                     r_break <= 1'b1;
                     r_state <= StWaitIdle;
                  end else begin
                     r_err_frame <= 1'b1;
                     r_state     <= StWaitIdle;
                  end
               end
            end
            default: r_state <= StWaitIdle;
         endcase
      end
   end

   uart_rx_sfifo #(
      .WIDTH(DATA_BITS + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push),
      .i_data ({r_perr, r_shift}),
      .i_pop  (w_pop),
      .o_data (w_fifo_data),
      .o_valid(rx_valid),
      .o_full (w_full),
      .o_level(rx_level)
   );

   assign {rx_perr, rx_data} = w_fifo_data;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed and randomized frames into an 8N1 receiver (depth 4) and a 7E1 receiver
// (5 clocks per bit), compared against expected-frame queues.
module tb_uart_rx_fifo_param;

   localparam int unsigned CPB0 = 4;
   localparam int unsigned CPB1 = 5;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd0  = 1'b1;
   logic       rxd1  = 1'b1;
   logic       rdy0  = 1'b0;
   logic       rdy1  = 1'b0;
   logic [7:0] data0;
   logic [6:0] data1;
   logic       perr0, perr1, valid0, valid1;
   logic       ferr0, ferr1, ovr0, ovr1, brk0, brk1;
   logic [2:0] lvl0;
   logic [4:0] lvl1;

   int total = 0;
   int bad   = 0;
   int n_ferr0 = 0;
   int n_ferr1 = 0;
   int n_ovr0  = 0;
   int n_ovr1  = 0;
   logic [8:0] got0[$];
   logic [8:0] got1[$];
   logic [8:0] exp0[$];
   logic [8:0] exp1[$];

   always #5 clk = ~clk;

   uart_rx_fifo_param #(
      .CLKS_PER_BIT(CPB0),
      .DATA_BITS   (8),
      .PARITY      (0),
      .FIFO_DEPTH  (4)
   ) u_dut0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rxd   (rxd0),
      .rx_data    (data0),
      .rx_perr    (perr0),
      .rx_valid   (valid0),
      .rx_ready   (rdy0),
      .rx_level   (lvl0),
      .err_frame  (ferr0),
      .err_overrun(ovr0),
      .break_det  (brk0)
   );

   uart_rx_fifo_param #(
      .CLKS_PER_BIT(CPB1),
      .DATA_BITS   (7),
      .PARITY      (2),
      .FIFO_DEPTH  (16)
   ) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .uart_rxd   (rxd1),
      .rx_data    (data1),
      .rx_perr    (perr1),
      .rx_valid   (valid1),
      .rx_ready   (rdy1),
      .rx_level   (lvl1),
      .err_frame  (ferr1),
      .err_overrun(ovr1),
      .break_det  (brk1)
   );

   // Consumer side: every accepted handshake is a popped entry.
   always @(negedge clk) begin
      if (valid0 && rdy0) got0.push_back({perr0, data0});
      if (valid1 && rdy1) got1.push_back({1'b0, perr1, data1});
      if (ferr0) n_ferr0 <= n_ferr0 + 1;
      if (ferr1) n_ferr1 <= n_ferr1 + 1;
      if (ovr0)  n_ovr0  <= n_ovr0 + 1;
      if (ovr1)  n_ovr1  <= n_ovr1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Serialises n bits LSB first, then leaves two idle bit times.
   task automatic send_bits(input int d, input logic [15:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         if (d == 0) begin
            rxd0 = bits[i];
            tick(CPB0);
         end else begin
            rxd1 = bits[i];
            tick(CPB1);
         end
      end
      if (d == 0) begin
         rxd0 = 1'b1;
         tick(2 * CPB0);
      end else begin
         rxd1 = 1'b1;
         tick(2 * CPB1);
      end
   endtask

   task automatic frame0(input logic [7:0] d, input logic stop);
      send_bits(0, {6'd0, stop, d, 1'b0}, 10);
   endtask

   task automatic frame1(input logic [6:0] d, input logic pb);
      send_bits(1, {6'd0, 1'b1, pb, d, 1'b0}, 10);
   endtask

   // Even parity: an odd count of ones over data plus parity bit is an error.
   function automatic logic [8:0] model1(input logic [6:0] d, input logic pb);
      logic err;
      err = ($countones({d, pb}) % 2) != 0;
      return {1'b0, err, d};
   endfunction

   task automatic cmp_q(input string tag, input int d);
      logic [8:0] g[$];
      logic [8:0] e[$];
      if (d == 0) begin
         g = got0;
         e = exp0;
         got0.delete();
         exp0.delete();
      end else begin
         g = got1;
         e = exp1;
         got1.delete();
         exp1.delete();
      end
      chk({tag, "_count"}, g.size(), e.size());
      for (int i = 0; i < e.size(); i++) begin
         chk($sformatf("%s[%0d]", tag, i), (i < g.size()) ? 32'(g[i]) : 32'hDEAD, 32'(e[i]));
      end
   endtask

   initial begin
      logic [7:0] b;
      logic [6:0] s;
      logic       p;
      int         f;
      int         o;

      tick(3);
      chk("reset0", {valid0, lvl0, ferr0, ovr0, brk0, perr0, data0}, '0);
      chk("reset1", {valid1, lvl1, ferr1, ovr1, brk1, perr1, data1}, '0);
      rst_n = 1'b1;
      tick(4);

      rdy0 = 1'b1;
      frame0(8'hA5, 1'b1);
      exp0.push_back({1'b0, 8'hA5});
      frame0(8'h3C, 1'b1);
      exp0.push_back({1'b0, 8'h3C});
      tick(4);
      cmp_q("basic", 0);
      chk("basic_ferr", n_ferr0, 0);
      chk("basic_ovr", n_ovr0, 0);

      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom_range(0, 255));
         frame0(b, 1'b1);
         exp0.push_back({1'b0, b});
      end
      tick(4);
      cmp_q("rand0", 0);

      rdy1 = 1'b1;
      frame1(7'h07, 1'b1);
      exp1.push_back(model1(7'h07, 1'b1));
      frame1(7'h07, 1'b0);
      exp1.push_back(model1(7'h07, 1'b0));
      for (int i = 0; i < 8; i++) begin
         s = 7'($urandom_range(0, 127));
         p = 1'($urandom_range(0, 1));
         frame1(s, p);
         exp1.push_back(model1(s, p));
      end
      tick(4);
      cmp_q("parity", 1);

      f = n_ferr0;
      rxd0 = 1'b0;
      tick(2);
      rxd0 = 1'b1;
      tick(4 * CPB0);
      chk("glitch_nopush", got0.size(), 0);
      chk("glitch_noerr", n_ferr0, f);
      frame0(8'h5A, 1'b1);
      exp0.push_back({1'b0, 8'h5A});
      tick(4);
      cmp_q("after_glitch", 0);

      f = n_ferr0;
      frame0(8'h55, 1'b0);
      tick(4);
      chk("frame_err_once", n_ferr0, f + 1);
      chk("frame_nopush", got0.size(), 0);
      chk("frame_nobreak", brk0, 1'b0);

      f = n_ferr0;
      rxd0 = 1'b0;
      tick(20 * CPB0);
      chk("break_set", brk0, 1'b1);
      chk("break_nopush", got0.size(), 0);
      chk("break_noferr", n_ferr0, f);
      rxd0 = 1'b1;
      tick(6);
      chk("break_clear", brk0, 1'b0);
      tick(2 * CPB0);

      rdy0 = 1'b0;
      o = n_ovr0;
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom_range(0, 255));
         frame0(b, 1'b1);
         if (i < 4) exp0.push_back({1'b0, b});
      end
      chk("ovr_level", lvl0, 4);
      chk("ovr_pulse", n_ovr0, o + 1);
      rdy0 = 1'b1;
      tick(8);
      cmp_q("ovr_data", 0);
      chk("ovr_drained", lvl0, 0);

      rdy0 = 1'b0;
      frame0(8'hC3, 1'b1);
      chk("pre_rst_level", lvl0, 1);
      f = n_ferr0;
      rxd0 = 1'b0;
      tick(4 * CPB0);
      rst_n = 1'b0;
      tick(2);
      chk("rst_mid_outputs", {valid0, lvl0, ferr0, ovr0, brk0, perr0, data0}, '0);
      rst_n = 1'b1;
      tick(20 * CPB0);
      chk("rst_low_level", lvl0, 0);
      chk("rst_low_break", brk0, 1'b0);
      chk("rst_low_ferr", n_ferr0, f);
      rxd0 = 1'b1;
      tick(2 * CPB0);
      rdy0 = 1'b1;
      frame0(8'h96, 1'b1);
      exp0.push_back({1'b0, 8'h96});
      tick(4);
      cmp_q("post_rst", 0);

      chk("dut1_no_ferr", n_ferr1, 0);
      chk("dut1_no_ovr", n_ovr1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
